// File: rtl/udsp_frame_sequencer_if.sv
// Data-memory write-port bundle for the uDSP frame sequencer: core writeback,
// host parameter/coefficient writes and the muxed memory write port.
interface udsp_frame_sequencer_if #(
   parameter int unsigned DAW = 10,
   parameter int unsigned DWW = 36
);
   logic [DAW-1:0] core_addrW;
   logic [DWW-1:0] core_dataW;
   logic           core_writeEn;
   logic           host_req;
   logic [DAW-1:0] host_addr;
   logic [DWW-1:0] host_wdata;
   logic           host_gnt;
   logic [DAW-1:0] mem_addrW;
   logic [DWW-1:0] mem_dataW;
   logic           mem_we;

   // Sequencer side: consumes write requests, drives the memory port.
   modport slave (
      input  core_addrW, core_dataW, core_writeEn,
      input  host_req, host_addr, host_wdata,
      output host_gnt,
      output mem_addrW, mem_dataW, mem_we
   );

   // Core/host/memory side.
   modport master (
      output core_addrW, core_dataW, core_writeEn,
      output host_req, host_addr, host_wdata,
      input  host_gnt,
      input  mem_addrW, mem_dataW, mem_we
   );
endinterface

// File: rtl/udsp_frame_sequencer.sv
// Per-sample controller for the uDSP core: starts one program pass per audio
// sample tick, times the pass plus pipeline drain, arbitrates the data-memory
// write port between core writeback and host writes, and counts overruns.
module udsp_frame_sequencer #(
   parameter int unsigned RUN_CYCLES   = 512,
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter int unsigned DAW          = 10,
   parameter int unsigned DWW          = 36,
   parameter int unsigned OCW          = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run_en,
   input  logic                 sample_tick,
   output logic                 core_start,
   output logic                 busy,
   output logic                 frame_done,
   udsp_frame_sequencer_if.slave bus,
   output logic [OCW-1:0]       overrun_count,
   input  logic                 clr_overrun
);

   localparam int unsigned CW = 16;

   typedef enum logic [1:0] {
      IDLE,
      START,
      RUN,
      DRAIN
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           pending_q, pending_d;
   logic [OCW-1:0] ovr_q, ovr_d;
   logic           core_start_q, core_start_d;
   logic           busy_q, busy_d;
   logic           frame_done_q, frame_done_d;

   logic           go;
   logic           drop;
   logic           host_gnt_c;
   logic [DAW-1:0] mem_addr_c;
   logic [DWW-1:0] mem_data_c;
   logic           mem_we_c;

   // A pass is requested by a fresh tick or a tick latched during the last pass.
   assign go = run_en && (sample_tick || pending_q);

   // Next-state, pass timing, pending/overrun bookkeeping and registered outputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      ovr_d     = ovr_q;
      drop      = 1'b0;

      case (state_q)
         IDLE: begin
            if (go) begin
               state_d   = START;
               pending_d = 1'b0;
            end
         end
         START: begin
            state_d = RUN;
            cnt_d   = CW'(RUN_CYCLES - 1);
         end
         RUN: begin
            if (cnt_q == '0) begin
               state_d = DRAIN;
               cnt_d   = CW'(DRAIN_CYCLES - 1);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DRAIN: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // One tick may wait behind a running pass; any further tick is dropped.
      if ((state_q != IDLE) && run_en && sample_tick) begin
         if (!pending_q) begin
            pending_d = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end

      if (clr_overrun) begin
         ovr_d = '0;
      end else if (drop && (ovr_q != '1)) begin
         ovr_d = ovr_q + OCW'(1);
      end

      // Outputs are decoded from the next state so they line up with the state flop.
      core_start_d = (state_d == START);
      busy_d       = (state_d != IDLE);
      frame_done_d = (state_d == DRAIN) && (cnt_d == '0);
   end

   // State and registered-output flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         pending_q    <= 1'b0;
         ovr_q        <= '0;
         core_start_q <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pending_q    <= pending_d;
         ovr_q        <= ovr_d;
         core_start_q <= core_start_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Host grant and write-port mux; core writes only land during RUN/DRAIN.
   always_comb begin
      host_gnt_c = (state_q == IDLE) && bus.host_req && !go;
      mem_addr_c = bus.core_addrW;
      mem_data_c = bus.core_dataW;
      mem_we_c   = 1'b0;
      if (host_gnt_c) begin
         mem_addr_c = bus.host_addr;
         mem_data_c = bus.host_wdata;
         mem_we_c   = 1'b1;
      end else if ((state_q == RUN) || (state_q == DRAIN)) begin
         mem_we_c = bus.core_writeEn;
      end
   end

   assign bus.host_gnt   = host_gnt_c;
   assign bus.mem_addrW  = mem_addr_c;
   assign bus.mem_dataW  = mem_data_c;
   assign bus.mem_we     = mem_we_c;

   assign core_start     = core_start_q;
   assign busy           = busy_q;
   assign frame_done     = frame_done_q;
   assign overrun_count  = ovr_q;

endmodule

// File: tb/tb_udsp_frame_sequencer.sv
// Directed testbench for udsp_frame_sequencer (RUN_CYCLES=8, DRAIN_CYCLES=2).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_udsp_frame_sequencer;

   logic       clk;
   logic       reset;
   logic       run_en;
   logic       sample_tick;
   logic       clr_overrun;
   logic       core_start;
   logic       busy;
   logic       frame_done;
   logic [7:0] overrun_count;

   int checks;
   int errors;

   localparam logic [9:0]  CORE_ADDR = 10'h3AA;
   localparam logic [35:0] CORE_DATA = 36'h0000ABCDE;
   localparam logic [9:0]  HOST_ADDR = 10'h105;
   localparam logic [35:0] HOST_DATA = 36'h123456789;

   udsp_frame_sequencer_if #(.DAW(10), .DWW(36)) bus ();

   udsp_frame_sequencer #(
      .RUN_CYCLES  (8),
      .DRAIN_CYCLES(2),
      .DAW         (10),
      .DWW         (36),
      .OCW         (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .run_en       (run_en),
      .sample_tick  (sample_tick),
      .core_start   (core_start),
      .busy         (busy),
      .frame_done   (frame_done),
      .bus          (bus),
      .overrun_count(overrun_count),
      .clr_overrun  (clr_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_quiet();
      int idle_run;
      idle_run = 0;
      for (int i = 0; i < 100 && idle_run < 3; i++) begin
         @(negedge clk);
         if (!busy) idle_run++;
         else idle_run = 0;
      end
      cyc();
      checks++;
      if (idle_run < 3) begin
         errors++;
         $display("FAIL wait_quiet: idle_run=%0d required=3", idle_run);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({core_start, busy, frame_done, bus.mem_we, bus.host_gnt} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs: got=%b required=00000",
                  {core_start, busy, frame_done, bus.mem_we, bus.host_gnt});
      end
      checks++;
      if (overrun_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_overrun: got=%0d required=0", overrun_count);
      end
      cyc();
      reset  = 1'b0;
      run_en = 1'b1;
      for (int i = 0; i < 8; i++) cyc();
   endtask

   task automatic test_basic_pass();
      logic [3:0] exp, got;
      for (int k = 0; k < 14; k++) begin
         sample_tick = (k == 0);
         @(negedge clk);
         exp = {k == 1, (k >= 1 && k <= 11), k == 11, (k >= 2 && k <= 11)};
         got = {core_start, busy, frame_done, bus.mem_we};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL basic_pass k=%0d start/busy/done/we: got=%b required=%b", k, got, exp);
         end
         if (k == 5) begin
            checks++;
            if ({bus.mem_addrW, bus.mem_dataW} !== {CORE_ADDR, CORE_DATA}) begin
               errors++;
               $display("FAIL basic_pass_core_write: got=%h/%h required=%h/%h",
                        bus.mem_addrW, bus.mem_dataW, CORE_ADDR, CORE_DATA);
            end
         end
         cyc();
      end
      sample_tick = 1'b0;
   endtask

   task automatic test_host_arb();
      logic [1:0] exp, got;
      bus.host_req   = 1'b1;
      bus.host_addr  = HOST_ADDR;
      bus.host_wdata = HOST_DATA;
      @(negedge clk);
      checks++;
      if ({bus.host_gnt, bus.mem_we, bus.mem_addrW, bus.mem_dataW} !== {2'b11, HOST_ADDR, HOST_DATA}) begin
         errors++;
         $display("FAIL host_idle_grant: got gnt=%b we=%b %h/%h required gnt=1 we=1 %h/%h",
                  bus.host_gnt, bus.mem_we, bus.mem_addrW, bus.mem_dataW, HOST_ADDR, HOST_DATA);
      end
      cyc();
      for (int k = 0; k < 14; k++) begin
         sample_tick = (k == 0);
         @(negedge clk);
         exp = {k == 12, (k >= 2 && k <= 12)};
         got = {bus.host_gnt, bus.mem_we};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL host_conflict k=%0d gnt/we: got=%b required=%b", k, got, exp);
         end
         if (k == 12) begin
            checks++;
            if ({bus.mem_addrW, bus.mem_dataW} !== {HOST_ADDR, HOST_DATA}) begin
               errors++;
               $display("FAIL host_retry_data: got=%h/%h required=%h/%h",
                        bus.mem_addrW, bus.mem_dataW, HOST_ADDR, HOST_DATA);
            end
         end
         cyc();
         if (k == 12) bus.host_req = 1'b0;
      end
      sample_tick = 1'b0;
   endtask

   task automatic test_overrun();
      logic [3:0] exp, got;
      logic [7:0] exp_ovr;
      for (int k = 0; k < 26; k++) begin
         sample_tick = (k == 0) || (k == 3) || (k == 5) || (k == 7);
         @(negedge clk);
         exp = {(k == 1) || (k == 13), (k >= 1 && k <= 11) || (k >= 13 && k <= 23),
                (k == 11) || (k == 23), 1'b0};
         got = {core_start, busy, frame_done, 1'b0};
         exp_ovr = (k <= 5) ? 8'd0 : ((k <= 7) ? 8'd1 : 8'd2);
         checks++;
         if (got !== exp || overrun_count !== exp_ovr) begin
            errors++;
            $display("FAIL overrun_pass k=%0d start/busy/done=%b ovr=%0d required %b ovr=%0d",
                     k, got[3:1], overrun_count, exp[3:1], exp_ovr);
         end
         cyc();
      end
      sample_tick = 1'b0;

      // Continuous ticks: every busy cycle after the first latched tick is dropped.
      sample_tick = 1'b1;
      for (int i = 0; i < 400; i++) cyc();
      @(negedge clk);
      checks++;
      if (overrun_count !== 8'd255) begin
         errors++;
         $display("FAIL overrun_saturate: got=%0d required=255", overrun_count);
      end

      // Clear coinciding with an overflowing tick in the first RUN cycle.
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (core_start) seen = 1'b1;
         end
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL overrun_find_start: got no core_start required core_start within 20 cycles");
         end
      end
      cyc();
      clr_overrun = 1'b1;
      cyc();
      clr_overrun = 1'b0;
      @(negedge clk);
      checks++;
      if (overrun_count !== 8'd0) begin
         errors++;
         $display("FAIL overrun_clear_wins: got=%0d required=0", overrun_count);
      end
      cyc();
      @(negedge clk);
      checks++;
      if (overrun_count !== 8'd1) begin
         errors++;
         $display("FAIL overrun_after_clear: got=%0d required=1", overrun_count);
      end
      sample_tick = 1'b0;
      wait_quiet();
      clr_overrun = 1'b1;
      cyc();
      clr_overrun = 1'b0;
      @(negedge clk);
      checks++;
      if (overrun_count !== 8'd0) begin
         errors++;
         $display("FAIL overrun_clear_idle: got=%0d required=0", overrun_count);
      end
      cyc();
   endtask

   task automatic test_run_en_off();
      logic [3:0] exp, got;
      run_en = 1'b0;
      for (int k = 0; k < 8; k++) begin
         sample_tick = (k == 1) || (k == 3) || (k == 5);
         @(negedge clk);
         checks++;
         if ({core_start, busy} !== 2'b00 || overrun_count !== 8'd0) begin
            errors++;
            $display("FAIL run_en_off_idle k=%0d start/busy=%b ovr=%0d required 00 ovr=0",
                     k, {core_start, busy}, overrun_count);
         end
         cyc();
      end
      sample_tick = 1'b0;
      run_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL run_en_no_pending k=%0d busy: got=%b required=0", k, busy);
         end
         cyc();
      end
      for (int k = 0; k < 21; k++) begin
         sample_tick = (k == 0) || (k == 4) || (k == 8);
         run_en      = !(k >= 6 && k < 17);
         @(negedge clk);
         exp = {(k == 1) || (k == 18), (k >= 1 && k <= 11) || (k >= 18), k == 11, 1'b0};
         got = {core_start, busy, frame_done, 1'b0};
         checks++;
         if (got !== exp || overrun_count !== 8'd0) begin
            errors++;
            $display("FAIL run_en_pending k=%0d start/busy/done=%b ovr=%0d required %b ovr=0",
                     k, got[3:1], overrun_count, exp[3:1]);
         end
         cyc();
      end
      sample_tick = 1'b0;
      run_en = 1'b1;
      wait_quiet();
   endtask

   task automatic test_reset_mid_run();
      logic [3:0] exp, got;
      for (int k = 0; k < 6; k++) begin
         sample_tick = (k == 0);
         cyc();
      end
      sample_tick = 1'b0;
      // Now 1 ns into the RUN cycle with counter = 3.
      #1;
      checks++;
      if ({busy, bus.mem_we} !== 2'b11) begin
         errors++;
         $display("FAIL reset_pre_run busy/we: got=%b required=11", {busy, bus.mem_we});
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({core_start, busy, frame_done, bus.mem_we} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_async start/busy/done/we: got=%b required=0000",
                  {core_start, busy, frame_done, bus.mem_we});
      end
      cyc();
      reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         checks++;
         if ({busy, frame_done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_aborted k=%0d busy/done: got=%b required=00", k, {busy, frame_done});
         end
         cyc();
      end
      for (int k = 0; k < 14; k++) begin
         sample_tick = (k == 0);
         @(negedge clk);
         exp = {k == 1, (k >= 1 && k <= 11), k == 11, (k >= 2 && k <= 11)};
         got = {core_start, busy, frame_done, bus.mem_we};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL reset_next_pass k=%0d start/busy/done/we: got=%b required=%b", k, got, exp);
         end
         cyc();
      end
      sample_tick = 1'b0;
   endtask

   initial begin
      checks           = 0;
      errors           = 0;
      reset            = 1'b1;
      run_en           = 1'b0;
      sample_tick      = 1'b0;
      clr_overrun      = 1'b0;
      bus.core_writeEn = 1'b1;
      bus.core_addrW   = CORE_ADDR;
      bus.core_dataW   = CORE_DATA;
      bus.host_req     = 1'b0;
      bus.host_addr    = '0;
      bus.host_wdata   = '0;

      test_reset();
      test_basic_pass();
      test_host_arb();
      test_overrun();
      test_run_en_off();
      test_reset_mid_run();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/udsp_frame_sequencer.md
Name: udsp_frame_sequencer

Overview:
- Per-sample controller for the uDSP core.
- On each audio sample tick it pulses the core's start, times one full program pass plus the 2-stage pipeline drain, then returns to idle.
- Owns the data-memory write port. It muxes core writeback and host parameter/coefficient writes, granting the host only between passes.
- Detects and counts sample overruns.

Parameters:
- RUN_CYCLES, 512, cycles per program pass (instruction ROM depth); range 1..65535
- DRAIN_CYCLES, 2, extra cycles after the pass so the final EX and WB writes land; range 1..15
- DAW, 10, data memory address width (3-bit segment + 7-bit word)
- DWW, 36, data word width
- OCW, 8, overrun counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- run_en  in  1  1 = respond to sample ticks; 0 = ticks ignored
- sample_tick  in  1  one-cycle pulse per audio sample
- core_start  out  1  to the uDSP start input
- busy  out  1  high whenever state != IDLE
- frame_done  out  1  one-cycle pulse when a pass completes
- core_addrW  in  DAW  core writeback address
- core_dataW  in  DWW  core writeback data
- core_writeEn  in  1  core writeback enable
- host_req  in  1  host write request; host holds it until granted
- host_addr  in  DAW  host write address
- host_wdata  in  DWW  host write data
- host_gnt  out  1  host write performed this cycle
- mem_addrW  out  DAW  data memory write address
- mem_dataW  out  DWW  data memory write data
- mem_we  out  1  data memory write enable
- overrun_count  out  OCW  saturating count of dropped ticks
- clr_overrun  in  1  synchronous clear of overrun_count

Behaviour:
- Reset (async) puts the block in these states:
  - state = IDLE; pending = 0; cycle counter = 0; overrun_count = 0.
  - core_start, busy, frame_done, host_gnt and mem_we are all 0.
  - Reset mid-pass aborts the pass. No frame_done is issued.
- FSM states: IDLE, START, RUN, DRAIN.
  - IDLE -> START when run_en and (sample_tick or pending). Clear pending on this transition.
  - START lasts exactly 1 cycle with core_start = 1. The core PC is 0 at the next edge. Then load counter = RUN_CYCLES-1 and go to RUN.
  - RUN decrements the counter each cycle. At counter = 0, load DRAIN_CYCLES-1 and go to DRAIN.
  - DRAIN decrements the counter. At counter = 0, go to IDLE with frame_done = 1 in that last DRAIN cycle.
  - Total busy time per pass is 1 + RUN_CYCLES + DRAIN_CYCLES cycles.
  - core_start is registered and is high only in START.
- Tick while busy:
  - If pending = 0, set pending = 1.
  - If pending = 1, the tick is dropped and overrun_count increments. It saturates at 2^OCW-1.
  - A pending tick starts the next pass on the first IDLE cycle: IDLE lasts exactly 1 cycle, then START.
- run_en = 0:
  - Ticks are neither latched nor counted.
  - pending is held. It is serviced once run_en returns to 1.
  - A pass in progress always completes.
- clr_overrun:
  - Clears overrun_count to 0 at the next edge.
  - If clr_overrun and an overflowing tick occur in the same cycle, the result is 0 (clear wins).
- Host grant:
  - host_gnt is combinational: state == IDLE and host_req and not (run_en and (sample_tick or pending)).
  - The tick wins a same-cycle conflict. In that case the host is not granted and must retry.
  - At most one host write per cycle. The write occurs in the same cycle as host_gnt.
- Write mux:
  - When host_gnt: mem_* = host_addr, host_wdata, and mem_we = 1.
  - Else when state is RUN or DRAIN: mem_* = core_*, passing core_writeEn through.
  - Else (IDLE without grant, or START): mem_we = 0, and mem_addrW/mem_dataW = core values (don't care).
  - Core writes outside RUN/DRAIN are always masked. This prevents free-running PC runout from corrupting memory.
- No cross-cycle data dependency. All outputs except host_gnt and the mem_* mux outputs are registered.

Test Plan:
- Bench uses RUN_CYCLES=8, DRAIN_CYCLES=2.
- Basic pass: reset, run_en=1, tick at cycle 10 -> core_start=1 in cycle 11 only; busy high cycles 11..21; frame_done=1 in cycle 21 only; IDLE at 22.
- Write masking: core_writeEn=1 held constant from cycle 0 -> mem_we=1 only in cycles 12..21, i.e. RUN+DRAIN, the same 10 cycles each pass.
- Host arbitration: host_req=1 at addr 0x105, data 0x123456789 while idle -> host_gnt=1 and mem_we=1 with those values that cycle. Same request asserted with a coincident tick -> host_gnt=0; granted in the first IDLE cycle after frame_done.
- Overrun: 3 ticks during one pass -> first latched, next pass starts 1 cycle after frame_done, overrun_count=2. 300 excess ticks -> saturates at 255. clr_overrun -> 0.
- run_en=0: ticks during IDLE -> no core_start, pending stays 0, overrun_count unchanged. Tick during a pass then run_en=0 -> the pending pass starts 1 cycle after run_en returns to 1.
- Async reset in RUN at counter=3 -> busy, core_start and mem_we go to 0 immediately; no frame_done. Next tick starts a normal full-length pass.
